decode_scoreboard: RTL and testbench
====================================

// Module: decode_scoreboard
// PURPOSE
// - Dual-issue decode-stage hazard unit, sits beside the decode operand-forwarding mux.
// - Forwarding covers results already on the bypass network. This block tracks "late" producers:
//   loads, mul/div, mfc0 and hi/lo reads, whose value is not forwardable before writeback.
// - Stalls decode slots that read a register with a late producer still in flight.
// - Produces the per-slot issue fire vector.
// PARAMETERS
// - NSLOT   2   decode/writeback slots per cycle; the RTL supports only 2
// - CNT_W   2   width of the per-register in-flight counter; max outstanding = 2**CNT_W-1
// PORTS
// - clk          in   1      clock; one clock domain
// - reset        in   1      synchronous, active-high reset
// - flush        in   1      pipeline flush (exception/eret); kills all in-flight producers
// - ex_ready     in   1      backend can accept an issue this cycle
// - dec_valid    in   [2]    decode slot i holds an instruction
// - dec_src0/1   in   [2]x5  creg_addr_t source registers per slot; 0 = unused
// - dec_dst      in   [2]x5  creg_addr_t destination register; 0 = none
// - dec_late     in   [2]    destination is produced late
// - wb_valid     in   [2]    writeback slot i commits
// - wb_dst       in   [2]x5  writeback destination
// - wb_late      in   [2]    the committing instruction was a late producer
// - issue_fire   out  [2]    combinational; slot i issues this cycle
// - busy_vec     out  32     registered; bit r set when count[r] != 0
// - stall_cycles out  32     registered; count of cycles with dec_valid[0] & ~issue_fire[0]
// BEHAVIOUR
// - State: count[1..31], each CNT_W bits. count[0] does not exist; r0 is never busy.
// - Reset: all counts 0, busy_vec 0, stall_cycles 0. issue_fire is 0 while reset is high.
// - Source ready: src==0, or count[src]==0, or count[src]==1 with a same-cycle
//   wb_valid&wb_late&wb_dst==src. In that last case the value arrives through the forwarding mux.
// - ok[i]: every source ready, AND (dec_late[i]==0 OR dec_dst==0 OR count[dst] < max).
//   The second term prevents counter saturation.
// - issue_fire[0] = dec_valid[0] & ok[0] & ex_ready & ~flush.
// - issue_fire[1] = issue_fire[0] & dec_valid[1] & ok[1] & ~pair_dep, where:
//   - pair_dep: slot0 dec_dst!=0 and matches slot1 src0/src1 while dec_late[0]. Non-late RAW pairs
//     are resolved downstream.
//   - Also forced 0 if both slots are late to the same dst and count[dst] >= max-1.
// - Slot 1 never issues without slot 0 (in-order).
// - Count update per register r, next cycle:
//   - +1 for each fired slot with dec_late & dec_dst==r.
//   - -1 for each wb slot with wb_valid & wb_late & wb_dst==r.
//   - Increments and decrements net in the same cycle. Two same-reg events in one direction
//     count as 2.
//   - Underflow (decrement at 0) holds at 0 and fires a simulation assertion; it is never
//     silently wrapped.
// - flush: all counts cleared next cycle. Issues and completions in the flush cycle are ignored.
//   Writebacks of killed instructions are guaranteed suppressed by the pipeline.
//   Non-killed older completions arrive before flush by construction.
// - busy_vec reflects post-update counts (1-cycle latency). stall_cycles wraps at 2^32.
// - reset mid-operation dominates flush and all other inputs.
// STRUCTURE
// - Package mycpu.svh gains sb_cnt_t (logic [CNT_W-1:0]) and a dec_req_t struct
//   {valid, src0, src1, dst, late}; the block reuses the existing creg_addr_t.
// - One sub-module: sb_entry, a single-register counter with inc[2]/dec[2]/clear inputs,
//   busy/full outputs and the underflow assertion. 31 instances via generate.
// - Top level holds source-ready lookup, pair logic, issue_fire and the perf counter.
// TESTING
// - Reset: reset=1 for 2 cycles with random inputs -> busy_vec=0, issue_fire=0, stall_cycles=0.
// - Load-use: fire lw dst=5 late -> busy_vec[5]=1. Next op src0=5 -> fire=0 each cycle and
//   stall_cycles increments. wb_late dst=5 -> that same cycle fire[0]=1; next cycle busy_vec[5]=0.
// - Pair dependency: slot0 lw dst=8 late, slot1 addu src0=8 -> fire=2'b01.
//   Same pair with slot0 non-late -> fire=2'b11.
// - Saturation, CNT_W=2: three lw to r9 issued -> count 3. A fourth lw dst=9 -> fire[0]=0
//   until one wb dst=9 commits.
// - Flush: lw r3, mult hi/lo writer late dst=4 in flight; flush=1 with a same-cycle issue
//   -> fire=0, next cycle busy_vec=0.
// - Simultaneous: count[7]=1, same cycle fire lw dst=7 and wb_late dst=7 -> count[7] stays 1.
//   Double wb dst=7 at count 2 -> 0.

Source files
------------

// File: rtl/decode_scoreboard_pkg.sv
// decode_scoreboard_pkg: shared types and sizing for the decode-stage late-producer scoreboard
package decode_scoreboard_pkg;
    localparam int NSLOT   = 2;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [4:0]       creg_addr_t;
    typedef logic [CNT_W-1:0] sb_cnt_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t src0;
        creg_addr_t src1;
        creg_addr_t dst;
        logic       late;
    } dec_req_t;

    function automatic logic wb_match(logic [1:0] v, logic [1:0] l, logic [9:0] d, creg_addr_t r);
        return (v[0] & l[0] & (d[4:0] == r)) | (v[1] & l[1] & (d[9:5] == r));
    endfunction
endpackage

// File: rtl/decode_scoreboard_sb_entry.sv
// sb_entry: in-flight late-producer counter for one register; clamps at zero on underflow
module sb_entry
    import decode_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             full
);
    logic [CNT_W:0]   sum, ndec;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc[0]) + (CNT_W+1)'(inc[1]);
        ndec  = (CNT_W+1)'(dec[0]) + (CNT_W+1)'(dec[1]);
        cnt_d = (clear || sum < ndec) ? '0 : CNT_W'(sum - ndec);
    end

    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
        if (!reset && !clear) assert (sum >= ndec);
    end

    assign cnt  = cnt_q;
    assign busy = cnt_q != '0;
    assign full = cnt_q == CNT_W'(CNT_MAX);
endmodule

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: dual-issue decode hazard unit stalling readers of in-flight late producers
module decode_scoreboard
    import decode_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ex_ready,
    input  logic [1:0]  dec_valid,
    input  logic [9:0]  dec_src0,
    input  logic [9:0]  dec_src1,
    input  logic [9:0]  dec_dst,
    input  logic [1:0]  dec_late,
    input  logic [1:0]  wb_valid,
    input  logic [9:0]  wb_dst,
    input  logic [1:0]  wb_late,
    output logic [1:0]  issue_fire,
    output logic [31:0] busy_vec,
    output logic [31:0] stall_cycles
);
    dec_req_t    req [NSLOT];
    sb_cnt_t     cnt [32];
    logic [31:0] full;
    logic [1:0]  ok;
    logic        pair_dep, same_full;
    logic [31:0] stall_cycles_d, stall_cycles_q;

    // a count of 1 retiring this cycle is picked up by the forwarding mux
    function automatic logic src_rdy(creg_addr_t s, sb_cnt_t c, logic hit);
        return s == '0 || c == '0 || (c == sb_cnt_t'(1) && hit);
    endfunction

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            req[i] = '{valid: dec_valid[i], src0: dec_src0[i*5 +: 5], src1: dec_src1[i*5 +: 5],
                       dst: dec_dst[i*5 +: 5], late: dec_late[i]};
            ok[i]  = src_rdy(req[i].src0, cnt[req[i].src0], wb_match(wb_valid, wb_late, wb_dst, req[i].src0))
                   & src_rdy(req[i].src1, cnt[req[i].src1], wb_match(wb_valid, wb_late, wb_dst, req[i].src1))
                   & (~req[i].late | (req[i].dst == '0) | ~full[req[i].dst]);
        end
        pair_dep  = req[0].late & (req[0].dst != '0)
                  & ((req[0].dst == req[1].src0) | (req[0].dst == req[1].src1));
        same_full = req[0].late & req[1].late & (req[0].dst == req[1].dst) & (req[0].dst != '0)
                  & (cnt[req[0].dst] >= sb_cnt_t'(CNT_MAX - 1));
        issue_fire[0]  = ~reset & req[0].valid & ok[0] & ex_ready & ~flush;
        issue_fire[1]  = issue_fire[0] & req[1].valid & ok[1] & ~pair_dep & ~same_full;
        stall_cycles_d = stall_cycles_q + 32'(req[0].valid & ~issue_fire[0]);
    end

    always_ff @(posedge clk) begin
        stall_cycles_q <= reset ? '0 : stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
    assign cnt[0]       = '0;
    assign busy_vec[0]  = 1'b0;
    assign full[0]      = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_ent
        sb_entry u_ent (
            .clk   (clk),
            .reset (reset),
            .clear (flush),
            .inc   ({issue_fire[1] & dec_late[1] & (dec_dst[9:5] == 5'(r)),
                     issue_fire[0] & dec_late[0] & (dec_dst[4:0] == 5'(r))}),
            .dec   ({wb_valid[1] & wb_late[1] & (wb_dst[9:5] == 5'(r)),
                     wb_valid[0] & wb_late[0] & (wb_dst[4:0] == 5'(r))}),
            .cnt   (cnt[r]),
            .busy  (busy_vec[r]),
            .full  (full[r])
        );
    end
endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: directed vectors with hand-computed expectations for decode_scoreboard
module tb_decode_scoreboard;
    logic        clk = 1'b0;
    logic        reset, flush, ex_ready;
    logic [1:0]  dec_valid, dec_late, wb_valid, wb_late, issue_fire;
    logic [9:0]  dec_src0, dec_src1, dec_dst, wb_dst;
    logic [31:0] busy_vec, stall_cycles;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    decode_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .dec_valid    (dec_valid),
        .dec_src0     (dec_src0),
        .dec_src1     (dec_src1),
        .dec_dst      (dec_dst),
        .dec_late     (dec_late),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .wb_late      (wb_late),
        .issue_fire   (issue_fire),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = '0; dec_src0 = '0; dec_src1 = '0; dec_dst = '0; dec_late = '0;
        wb_valid = '0; wb_dst = '0; wb_late = '0; flush = 1'b0;
    endtask

    task automatic sd(input int i, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [4:0] d, input logic l);
        dec_valid[i] = v; dec_src0[i*5 +: 5] = s0; dec_src1[i*5 +: 5] = s1;
        dec_dst[i*5 +: 5] = d; dec_late[i] = l;
    endtask

    task automatic wb(input int i, input logic v, input logic [4:0] d, input logic l);
        wb_valid[i] = v; wb_dst[i*5 +: 5] = d; wb_late[i] = l;
    endtask

    initial begin
        reset = 1'b1; ex_ready = 1'b1; idle();
        repeat (2) begin
            dec_valid = 2'($urandom); dec_src0 = 10'($urandom); dec_src1 = 10'($urandom);
            dec_dst = 10'($urandom); dec_late = 2'($urandom); wb_valid = 2'($urandom);
            wb_dst = 10'($urandom); wb_late = 2'($urandom); flush = 1'($urandom);
            #1 check("rst_fire", 32'(issue_fire), 0);
            tick();
        end
        check("rst_busy", busy_vec, 0);
        check("rst_stall", stall_cycles, 0);
        idle(); reset = 1'b0;
        tick();

        // load-use on r5
        sd(0, 1, 0, 0, 5, 1);
        #1 check("lw_fire", 32'(issue_fire), 1);
        tick();
        check("lw_busy", busy_vec, 32'h20);
        sd(0, 1, 5, 0, 6, 0);
        #1 check("use_stall_a", 32'(issue_fire), 0);
        tick();
        check("stall_1", stall_cycles, 1);
        check("use_stall_b", 32'(issue_fire), 0);
        tick();
        check("stall_2", stall_cycles, 2);
        wb(0, 1, 5, 1);
        #1 check("wb_fwd_fire", 32'(issue_fire), 1);
        tick(); idle();
        check("wb_busy_clr", busy_vec, 0);
        check("stall_hold", stall_cycles, 2);

        // pair dependency through r8
        sd(0, 1, 1, 2, 8, 0); sd(1, 1, 8, 0, 10, 0);
        #1 check("pair_nonlate", 32'(issue_fire), 3);
        tick();
        sd(0, 1, 1, 2, 8, 1);
        #1 check("pair_late", 32'(issue_fire), 1);
        tick(); idle();
        check("pair_busy", busy_vec, 32'h100);
        wb(1, 1, 8, 1);
        tick(); idle();
        check("pair_drain", busy_vec, 0);

        // saturation of r9
        sd(0, 1, 0, 0, 9, 1); sd(1, 1, 0, 0, 9, 1);
        #1 check("sat_dual", 32'(issue_fire), 3);
        tick(); idle();
        check("sat_busy", busy_vec, 32'h200);
        sd(0, 1, 0, 0, 9, 1);
        #1 check("sat_third", 32'(issue_fire), 1);
        tick();
        check("sat_full_a", 32'(issue_fire), 0);
        tick();
        check("sat_full_b", 32'(issue_fire), 0);
        tick();
        wb(0, 1, 9, 1);
        #1 check("sat_full_wb", 32'(issue_fire), 0);
        tick();
        wb(0, 0, 0, 0); sd(1, 1, 0, 0, 9, 1);
        #1 check("sat_same_dst", 32'(issue_fire), 1);
        tick(); idle();
        check("sat_stall", stall_cycles, 5);
        wb(0, 1, 9, 1); wb(1, 1, 9, 1);
        tick();
        check("sat_dbl_wb", busy_vec, 32'h200);
        wb(1, 0, 0, 0);
        tick(); idle();
        check("sat_drain", busy_vec, 0);

        // flush kills r3/r4 producers and the same-cycle issue
        sd(0, 1, 0, 0, 3, 1);
        tick();
        sd(0, 1, 0, 0, 4, 1);
        tick();
        check("fl_busy", busy_vec, 32'h18);
        sd(0, 1, 0, 0, 11, 1); flush = 1'b1;
        #1 check("fl_fire", 32'(issue_fire), 0);
        tick(); idle();
        check("fl_busy_clr", busy_vec, 0);
        check("fl_stall", stall_cycles, 6);

        // simultaneous inc/dec on r7
        sd(0, 1, 0, 0, 7, 1);
        tick();
        wb(0, 1, 7, 1);
        #1 check("sim_fire", 32'(issue_fire), 1);
        tick();
        check("sim_busy", busy_vec, 32'h80);
        wb(0, 0, 0, 0);
        tick(); idle();
        wb(0, 1, 7, 1); wb(1, 1, 7, 1);
        tick(); idle();
        check("sim_dbl_wb", busy_vec, 0);

        // reset mid-operation dominates flush and decode
        sd(0, 1, 0, 0, 2, 1);
        tick();
        check("mr_busy", busy_vec, 32'h4);
        reset = 1'b1; flush = 1'b1;
        #1 check("mr_fire", 32'(issue_fire), 0);
        tick();
        reset = 1'b0; idle();
        check("mr_busy_clr", busy_vec, 0);
        check("mr_stall", stall_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
